// File: rtl/byte_striping_cond.sv
// Transmit-side byte striper: pairs consecutive input bytes onto lane_0/lane_1
// and holds each registered pair for two clk_2f cycles (one clk_f period).
// A stream that ends on an odd byte emits that byte alone as an odd tail.
module byte_striping_cond #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic [CNT_W-1:0]  pair_count,
  output logic              odd_tail
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WAIT_B = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [1:0]        hold_q, hold_d;
  logic [DATA_W-1:0] lane0_q, lane0_d;
  logic [DATA_W-1:0] lane1_q, lane1_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              odd_q, odd_d;
  logic              upd;

  // Next state: capture byte A, then emit a full pair or an odd tail; otherwise age the hold.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hold_d  = hold_q;
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    cnt_d   = cnt_q;
    odd_d   = 1'b0;
    upd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          a_d     = data_in;
          state_d = S_WAIT_B;
        end
      end
      default: begin
        // Second byte or gap: either way the pair completes now.
        upd     = 1'b1;
        lane0_d = a_q;
        lane1_d = valid_in ? data_in : '0;
        v0_d    = 1'b1;
        v1_d    = valid_in;
        odd_d   = ~valid_in;
        cnt_d   = cnt_q + CNT_W'(1);
        hold_d  = 2'd2;
        state_d = S_IDLE;
      end
    endcase
    if (!upd && hold_q != 2'd0) begin
      hold_d = hold_q - 2'd1;
      // Last held cycle ends with no replacement: drop the pair.
      if (hold_q == 2'd1) begin
        lane0_d = '0;
        lane1_d = '0;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_2f) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      hold_q  <= 2'd0;
      lane0_q <= '0;
      lane1_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      cnt_q   <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hold_q  <= hold_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      cnt_q   <= cnt_d;
      odd_q   <= odd_d;
    end
  end

  assign lane_0     = lane0_q;
  assign lane_1     = lane1_q;
  assign valid_0    = v0_q;
  assign valid_1    = v1_q;
  assign pair_count = cnt_q;
  assign odd_tail   = odd_q;

endmodule

// File: tb/tb_byte_striping_cond.sv
// Bench for byte_striping_cond: hand tables for the basic scenarios plus a
// randomized stream checked against a timeline model of the expected outputs.
module tb_byte_striping_cond;

  logic       clk_2f = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [7:0] lane_0, lane_1;
  logic       valid_0, valid_1, odd_tail;
  logic [7:0] pair_count;
  logic [7:0] w_lane_0, w_lane_1;
  logic       w_valid_0, w_valid_1, w_odd_tail;
  logic [1:0] w_pair_count;

  always #5 clk_2f = ~clk_2f;

  byte_striping_cond #(.DATA_W(8), .CNT_W(8)) dut (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(lane_0), .lane_1(lane_1), .valid_0(valid_0), .valid_1(valid_1),
    .pair_count(pair_count), .odd_tail(odd_tail));

  byte_striping_cond #(.DATA_W(8), .CNT_W(2)) dut_w (
    .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .lane_0(w_lane_0), .lane_1(w_lane_1), .valid_0(w_valid_0), .valid_1(w_valid_1),
    .pair_count(w_pair_count), .odd_tail(w_odd_tail));

  int checks = 0;
  int errors = 0;

  localparam int TL = 8192;
  logic [7:0] e_l0 [TL];
  logic [7:0] e_l1 [TL];
  logic       e_v0 [TL];
  logic       e_v1 [TL];
  logic       e_odd[TL];
  int         e_cnt[TL];
  int         cyc = 0;
  bit         known = 0;
  bit         pend = 0;
  logic [7:0] pend_b;
  int         mcnt = 0;

  logic [7:0] o_l0, o_l1, o_cnt;
  logic       o_v0, o_v1, o_odd;
  logic [1:0] o_pc2;

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic [7:0] l0;
    logic [7:0] l1;
    logic       v0;
    logic       v1;
    logic       odd;
    logic [7:0] cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic sched(input int c, input logic [7:0] l0, input logic [7:0] l1,
                       input logic v0, input logic v1, input logic odd);
    if (c < TL) begin
      e_l0[c] = l0; e_l1[c] = l1; e_v0[c] = v0; e_v1[c] = v1; e_odd[c] = odd;
    end
  endtask

  // One clk_2f cycle: observe/check outputs of this cycle, drive its inputs, advance the model.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk_2f);
    o_l0 = lane_0; o_l1 = lane_1; o_v0 = valid_0; o_v1 = valid_1;
    o_odd = odd_tail; o_cnt = pair_count; o_pc2 = w_pair_count;
    if (known) begin
      check("lane_0", 32'(o_l0), 32'(e_l0[cyc]));
      check("lane_1", 32'(o_l1), 32'(e_l1[cyc]));
      check("valid_0", 32'(o_v0), 32'(e_v0[cyc]));
      check("valid_1", 32'(o_v1), 32'(e_v1[cyc]));
      check("odd_tail", 32'(o_odd), 32'(e_odd[cyc]));
      check("pair_count", 32'(o_cnt), 32'(e_cnt[cyc] % 256));
      check("pair_count_w2", 32'(o_pc2), 32'(e_cnt[cyc] % 4));
    end
    reset = r; valid_in = v; data_in = d;
    if (!r) begin
      known = 1; pend = 0; mcnt = 0;
      sched(cyc + 1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      sched(cyc + 2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end else if (pend) begin
      pend = 0; mcnt++;
      sched(cyc + 1, pend_b, v ? d : 8'h00, 1'b1, v, ~v);
      sched(cyc + 2, pend_b, v ? d : 8'h00, 1'b1, v, 1'b0);
    end else if (v) begin
      pend = 1; pend_b = d;
    end
    if (cyc + 1 < TL) e_cnt[cyc + 1] = mcnt;
    cyc++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF);
  endtask

  task automatic run_table(input string name, input vec_t t[7]);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, t[i].vin, t[i].din);
      check({name, ".lane_0"}, 32'(o_l0), 32'(t[i].l0));
      check({name, ".lane_1"}, 32'(o_l1), 32'(t[i].l1));
      check({name, ".valid_0"}, 32'(o_v0), 32'(t[i].v0));
      check({name, ".valid_1"}, 32'(o_v1), 32'(t[i].v1));
      check({name, ".odd_tail"}, 32'(o_odd), 32'(t[i].odd));
      check({name, ".pair_count"}, 32'(o_cnt), 32'(t[i].cnt));
    end
  endtask

  vec_t t_even[7];
  vec_t t_odd[7];
  vec_t t_sparse[7];
  logic [1:0] wrap_exp [5];

  initial begin
    for (int i = 0; i < TL; i++) begin
      e_l0[i] = 0; e_l1[i] = 0; e_v0[i] = 0; e_v1[i] = 0; e_odd[i] = 0; e_cnt[i] = 0;
    end
    t_even[0] = '{1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_even[1] = '{1'b1, 8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_even[2] = '{1'b1, 8'h12, 8'h10, 8'h11, 1'b1, 1'b1, 1'b0, 8'd1};
    t_even[3] = '{1'b1, 8'h13, 8'h10, 8'h11, 1'b1, 1'b1, 1'b0, 8'd1};
    t_even[4] = '{1'b0, 8'h00, 8'h12, 8'h13, 1'b1, 1'b1, 1'b0, 8'd2};
    t_even[5] = '{1'b0, 8'h00, 8'h12, 8'h13, 1'b1, 1'b1, 1'b0, 8'd2};
    t_even[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
    t_odd[0]  = '{1'b1, 8'hA0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_odd[1]  = '{1'b1, 8'hA1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_odd[2]  = '{1'b1, 8'hA2, 8'hA0, 8'hA1, 1'b1, 1'b1, 1'b0, 8'd1};
    t_odd[3]  = '{1'b0, 8'h00, 8'hA0, 8'hA1, 1'b1, 1'b1, 1'b0, 8'd1};
    t_odd[4]  = '{1'b0, 8'h00, 8'hA2, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2};
    t_odd[5]  = '{1'b0, 8'h00, 8'hA2, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2};
    t_odd[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
    t_sparse[0] = '{1'b1, 8'h55, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_sparse[1] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0};
    t_sparse[2] = '{1'b1, 8'h66, 8'h55, 8'h00, 1'b1, 1'b0, 1'b1, 8'd1};
    t_sparse[3] = '{1'b0, 8'h00, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    t_sparse[4] = '{1'b0, 8'h00, 8'h66, 8'h00, 1'b1, 1'b0, 1'b1, 8'd2};
    t_sparse[5] = '{1'b0, 8'h00, 8'h66, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2};
    t_sparse[6] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'd2};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset with valid_in held high: nothing may come out.
    do_reset();
    step(1'b1, 1'b0, 8'h00);
    check("reset.valid_0", 32'(o_v0), 32'd0);
    check("reset.lane_0", 32'(o_l0), 32'd0);
    check("reset.pair_count", 32'(o_cnt), 32'd0);

    do_reset(); run_table("even", t_even);
    do_reset(); run_table("odd", t_odd);
    do_reset(); run_table("sparse", t_sparse);

    // Reset mid-hold: 0x03 is captured, reset arrives with 0x04.
    do_reset();
    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h02);
    step(1'b1, 1'b1, 8'h03);
    step(1'b0, 1'b1, 8'h04);
    check("midrst.prev_lane_0", 32'(o_l0), 32'h01);
    step(1'b1, 1'b1, 8'h20);
    check("midrst.cleared_v0", 32'(o_v0), 32'd0);
    check("midrst.cleared_cnt", 32'(o_cnt), 32'd0);
    step(1'b1, 1'b1, 8'h21);
    step(1'b1, 1'b0, 8'h00);
    check("midrst.lane_0", 32'(o_l0), 32'h20);
    check("midrst.lane_1", 32'(o_l1), 32'h21);
    check("midrst.pair_count", 32'(o_cnt), 32'd1);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);

    // Odd tail immediately followed by a new byte that pairs normally.
    do_reset();
    step(1'b1, 1'b1, 8'h31);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h32);
    check("tailnext.odd_tail", 32'(o_odd), 32'd1);
    step(1'b1, 1'b1, 8'h33);
    step(1'b1, 1'b0, 8'h00);
    check("tailnext.lane_1", 32'(o_l1), 32'h33);
    check("tailnext.valid_1", 32'(o_v1), 32'd1);

    // pair_count wrap on the 2-bit counter instance.
    do_reset();
    for (int j = 0; j <= 10; j++) begin
      step(1'b1, (j < 10) ? 1'b1 : 1'b0, 8'(8'h40 + j));
      if (j >= 2 && (j % 2) == 0) check("wrap.pair_count", 32'(o_pc2), 32'(wrap_exp[(j - 2) / 2]));
    end

    // Random streams with varying density and occasional reset.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      int dens;
      dens = (k / 500) % 3;
      step(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1,
           (dens == 0) ? 1'b1 : (dens == 1) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 3) == 0),
           8'($urandom));
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
